// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared types and default timing for the LCD 4-bit writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

   // Width of the per-phase cycle counter
   localparam int CNT_W = 12;

   // Default phase lengths in clk cycles
   localparam int DEF_SETUP_CYC      = 2;
   localparam int DEF_ENABLE_CYC     = 12;
   localparam int DEF_HOLD_CYC       = 1;
   localparam int DEF_NIBBLE_GAP_CYC = 50;
   localparam int DEF_BYTE_WAIT_CYC  = 2000;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_SETUP_HI = 4'd1,
      S_EN_HI    = 4'd2,
      S_HOLD_HI  = 4'd3,
      S_GAP      = 4'd4,
      S_SETUP_LO = 4'd5,
      S_EN_LO    = 4'd6,
      S_HOLD_LO  = 4'd7,
      S_WAIT     = 4'd8
   } state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_phase_timer
//  Description : 12-bit phase counter with synchronous clear; flags the
//                cycle on which the count reaches the terminal value.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_phase_timer
   import lcd_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [CNT_W-1:0] terminal,
   output logic             last
);

   logic [CNT_W-1:0] count;

   // Count up each cycle; restart from zero whenever a phase begins
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign last = (count == terminal);

endmodule
`default_nettype wire

// File: rtl/lcd_byte_writer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_byte_writer
//  Description : Sends one command/data byte (or a single upper nibble) over
//                the character LCD 4-bit bus with setup/enable/hold timing
//                and a post-byte execution wait.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC      = DEF_SETUP_CYC,
   parameter int ENABLE_CYC     = DEF_ENABLE_CYC,
   parameter int HOLD_CYC       = DEF_HOLD_CYC,
   parameter int NIBBLE_GAP_CYC = DEF_NIBBLE_GAP_CYC,
   parameter int BYTE_WAIT_CYC  = DEF_BYTE_WAIT_CYC
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_rs,
   input  logic       in_nibble,
   output logic [3:0] lcd_d,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       busy,
   output logic       done
);

   // Terminal counts: a phase of N cycles ends when the counter shows N-1
   localparam logic [CNT_W-1:0] SETUP_T  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] ENABLE_T = CNT_W'(ENABLE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_T   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_T    = CNT_W'(NIBBLE_GAP_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_T   = CNT_W'(BYTE_WAIT_CYC - 1);

   state_t           state;
   logic [3:0]       lo_nibble;
   logic             nibble_only;
   logic [CNT_W-1:0] terminal;
   logic             last;
   logic             timer_clear;

   // Select the length of the phase currently in progress
   always_comb begin
      terminal = '0;
      case (state)
         S_SETUP_HI, S_SETUP_LO: terminal = SETUP_T;
         S_EN_HI,    S_EN_LO:    terminal = ENABLE_T;
         S_HOLD_HI,  S_HOLD_LO:  terminal = HOLD_T;
         S_GAP:                  terminal = GAP_T;
         S_WAIT:                 terminal = WAIT_T;
         default:                terminal = '0;
      endcase
   end

   // Holding the counter at zero in IDLE makes every phase start at count 0
   assign timer_clear = (state == S_IDLE) || last;

   lcd_phase_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (timer_clear),
      .terminal (terminal),
      .last     (last)
   );

   assign in_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);
   assign lcd_rw   = 1'b0;

   // Sequencer: pin values are registered alongside each state transition
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         lcd_d       <= 4'h0;
         lcd_e       <= 1'b0;
         lcd_rs      <= 1'b0;
         done        <= 1'b0;
         lo_nibble   <= 4'h0;
         nibble_only <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  lo_nibble   <= in_data[3:0];
                  nibble_only <= in_nibble;
                  lcd_rs      <= in_rs;
                  lcd_d       <= in_data[7:4];
                  state       <= S_SETUP_HI;
               end
            end
            S_SETUP_HI: if (last) begin
               lcd_e <= 1'b1;
               state <= S_EN_HI;
            end
            S_EN_HI: if (last) begin
               lcd_e <= 1'b0;
               state <= S_HOLD_HI;
            end
            S_HOLD_HI: if (last) begin
               state <= nibble_only ? S_WAIT : S_GAP;
            end
            S_GAP: if (last) begin
               lcd_d <= lo_nibble;
               state <= S_SETUP_LO;
            end
            S_SETUP_LO: if (last) begin
               lcd_e <= 1'b1;
               state <= S_EN_LO;
            end
            S_EN_LO: if (last) begin
               lcd_e <= 1'b0;
               state <= S_HOLD_LO;
            end
            S_HOLD_LO: if (last) begin
               state <= S_WAIT;
            end
            S_WAIT: if (last) begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lcd_byte_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_byte_writer
//  Description : Directed self-checking bench for lcd_byte_writer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_byte_writer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_valid2 = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_rs = 1'b0;
   logic       in_nibble = 1'b0;

   logic       in_ready, lcd_e, lcd_rs, lcd_rw, busy, done;
   logic [3:0] lcd_d;
   logic       in_ready2, lcd_e2, lcd_rs2, lcd_rw2, busy2, done2;
   logic [3:0] lcd_d2;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // Results of the most recent run_byte
   int         acc, prev_acc;
   int         rises, rise1, rise2, hi1, hi2, done_rel, timeout;
   int         err_rw, err_rs, err_d, extra;
   logic [3:0] d1, d2;

   lcd_byte_writer dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_rs(in_rs), .in_nibble(in_nibble),
      .lcd_d(lcd_d), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .busy(busy), .done(done)
   );

   lcd_byte_writer #(.ENABLE_CYC(1), .BYTE_WAIT_CYC(1)) dut_fast (
      .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_data(in_data), .in_rs(in_rs), .in_nibble(in_nibble),
      .lcd_d(lcd_d2), .lcd_e(lcd_e2), .lcd_rs(lcd_rs2), .lcd_rw(lcd_rw2),
      .busy(busy2), .done(done2)
   );

   always #5 clk = ~clk;

   // Edge counter; the accept edge is recorded from it
   always @(posedge clk) cyc <= cyc + 1;

   // Offer one byte, then watch every cycle (at negedge) until done.
   // rel numbers cycles with the cycle right after the accept edge as 1.
   task automatic run_byte(input logic [7:0] data, input logic rs, input logic nib,
                           input bit keep, input bit toggle);
      int         rel;
      int         n;
      logic       prev_e;
      logic [3:0] exp_d;
      rises = 0; rise1 = 0; rise2 = 0; hi1 = 0; hi2 = 0; done_rel = 0;
      timeout = 0; err_rw = 0; err_rs = 0; err_d = 0; extra = 0;
      d1 = 4'h0; d2 = 4'h0; prev_e = 1'b0;
      n = 0;
      while (!in_ready && n < 3000) begin @(negedge clk); n++; end
      in_data = data; in_rs = rs; in_nibble = nib; in_valid = 1'b1;
      @(posedge clk); #1;
      prev_acc = acc;
      acc = cyc;
      timeout = 1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         rel = cyc - acc + 1;
         if (lcd_e) begin
            if (!prev_e) begin
               rises++;
               if (rises == 1) begin rise1 = rel; d1 = lcd_d; end
               if (rises == 2) begin rise2 = rel; d2 = lcd_d; end
            end
            if (rises == 1) hi1++;
            if (rises == 2) hi2++;
         end
         prev_e = lcd_e;
         if (lcd_rw !== 1'b0) err_rw++;
         if (lcd_rs !== rs) err_rs++;
         exp_d = (nib || rel <= 65) ? data[7:4] : data[3:0];
         if (lcd_d !== exp_d) err_d++;
         if (!done && in_ready) extra++;
         if (done) begin
            done_rel = rel;
            timeout = 0;
            if (!keep) in_valid = 1'b0;
            break;
         end
         if (toggle && rel < 2060) begin
            in_valid = ~in_valid;
            in_data = 8'($urandom);
         end else if (!keep) begin
            in_valid = 1'b0;
         end
      end
      in_valid = keep ? in_valid : 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      if (lcd_d !== 4'h0)   begin fails++; $display("FAIL reset_d: got %0h need 0", lcd_d); end
      tests++;
      if ({lcd_e, lcd_rs, lcd_rw, busy, done} !== 5'b0) begin fails++; $display("FAIL reset_ctl: got %b need 00000", {lcd_e, lcd_rs, lcd_rw, busy, done}); end
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b need 1", in_ready); end
      tests++;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_cmd();
      run_byte(8'h28, 1'b0, 1'b0, 1'b0, 1'b0);
      if (timeout != 0) begin fails++; $display("FAIL cmd_timeout: got %0d need 0", timeout); end
      tests++;
      if (rises != 2)   begin fails++; $display("FAIL cmd_pulses: got %0d need 2", rises); end
      tests++;
      if (d1 !== 4'h2 || d2 !== 4'h8) begin fails++; $display("FAIL cmd_nibbles: got %0h,%0h need 2,8", d1, d2); end
      tests++;
      if (hi1 != 12 || hi2 != 12) begin fails++; $display("FAIL cmd_e_width: got %0d,%0d need 12,12", hi1, hi2); end
      tests++;
      if (rise1 != 3)   begin fails++; $display("FAIL cmd_first_rise: got %0d need 3", rise1); end
      tests++;
      if (rise2 - rise1 != 65) begin fails++; $display("FAIL cmd_rise_spacing: got %0d need 65", rise2 - rise1); end
      tests++;
      if (done_rel != 2081) begin fails++; $display("FAIL cmd_done_time: got %0d need 2081", done_rel); end
      tests++;
      if (err_rw != 0 || err_rs != 0 || err_d != 0 || extra != 0) begin
         fails++; $display("FAIL cmd_pins: rw %0d rs %0d d %0d ready %0d errors, need 0", err_rw, err_rs, err_d, extra);
      end
      tests++;
      @(negedge clk);
      if (done !== 1'b0) begin fails++; $display("FAIL cmd_done_pulse: got %b need 0", done); end
      tests++;
      if (lcd_d !== 4'h8 || lcd_rs !== 1'b0) begin fails++; $display("FAIL cmd_idle_hold: got d=%0h rs=%b need 8,0", lcd_d, lcd_rs); end
      tests++;
   endtask

   task automatic test_back_to_back();
      run_byte(8'h41, 1'b1, 1'b0, 1'b1, 1'b0);
      if (d1 !== 4'h4 || d2 !== 4'h1 || err_rs != 0 || err_d != 0) begin
         fails++; $display("FAIL b2b_first: got %0h,%0h rs_err %0d d_err %0d need 4,1,0,0", d1, d2, err_rs, err_d);
      end
      tests++;
      run_byte(8'h42, 1'b1, 1'b0, 1'b0, 1'b0);
      if (acc - prev_acc != 2081) begin fails++; $display("FAIL b2b_period: got %0d need 2081", acc - prev_acc); end
      tests++;
      if (d1 !== 4'h4 || d2 !== 4'h2 || err_rs != 0 || err_d != 0) begin
         fails++; $display("FAIL b2b_second: got %0h,%0h rs_err %0d d_err %0d need 4,2,0,0", d1, d2, err_rs, err_d);
      end
      tests++;
   endtask

   task automatic test_nibble();
      run_byte(8'h30, 1'b0, 1'b1, 1'b0, 1'b0);
      if (rises != 1 || d1 !== 4'h3 || hi1 != 12) begin
         fails++; $display("FAIL nib_pulse: got %0d pulses d=%0h width %0d need 1,3,12", rises, d1, hi1);
      end
      tests++;
      if (done_rel != 2016) begin fails++; $display("FAIL nib_done_time: got %0d need 2016", done_rel); end
      tests++;
      in_nibble = 1'b0;
   endtask

   task automatic test_busy_ignore();
      run_byte(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      if (extra != 0) begin fails++; $display("FAIL busy_ready: got %0d ready cycles need 0", extra); end
      tests++;
      if (err_d != 0 || d1 !== 4'hA || d2 !== 4'h5) begin
         fails++; $display("FAIL busy_data: got %0h,%0h d_err %0d need A,5,0", d1, d2, err_d);
      end
      tests++;
      if (done_rel != 2081) begin fails++; $display("FAIL busy_done_time: got %0d need 2081", done_rel); end
      tests++;
   endtask

   task automatic test_reset_mid();
      int rel;
      int dones;
      in_data = 8'h6C; in_rs = 1'b1; in_nibble = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      in_valid = 1'b0;
      rel = 0;
      while (rel < 70) begin @(negedge clk); rel = cyc - acc + 1; end
      if (lcd_e !== 1'b1 || lcd_d !== 4'hC) begin fails++; $display("FAIL rst_pre_en_lo: got e=%b d=%0h need 1,C", lcd_e, lcd_d); end
      tests++;
      #2 reset = 1'b1;
      #1;
      if (lcd_e !== 1'b0) begin fails++; $display("FAIL rst_async_e: got %b need 0", lcd_e); end
      tests++;
      if ({lcd_d, lcd_rs, busy, done, in_ready} !== 8'b0000_0001) begin
         fails++; $display("FAIL rst_async_outs: got %b need 00000001", {lcd_d, lcd_rs, busy, done, in_ready});
      end
      tests++;
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) dones++;
      end
      if (dones != 0 || busy !== 1'b0) begin fails++; $display("FAIL rst_no_done: got %0d dones busy=%b need 0,0", dones, busy); end
      tests++;
      run_byte(8'h28, 1'b0, 1'b0, 1'b0, 1'b0);
      if (done_rel != 2081 || d1 !== 4'h2 || d2 !== 4'h8 || err_d != 0) begin
         fails++; $display("FAIL rst_recover: got done %0d d %0h,%0h d_err %0d need 2081,2,8,0", done_rel, d1, d2, err_d);
      end
      tests++;
   endtask

   task automatic test_override();
      int a2, rel, r2, h2, dr, hmax;
      logic pe;
      r2 = 0; h2 = 0; dr = 0; hmax = 0; pe = 1'b0;
      in_data = 8'h28; in_rs = 1'b0; in_nibble = 1'b0; in_valid2 = 1'b1;
      @(posedge clk); #1;
      a2 = cyc;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         in_valid2 = 1'b0;
         rel = cyc - a2 + 1;
         if (lcd_e2) begin
            if (!pe) begin r2++; h2 = 0; end
            h2++;
            if (h2 > hmax) hmax = h2;
         end
         pe = lcd_e2;
         if (done2) begin dr = rel; break; end
      end
      if (r2 != 2 || hmax != 1) begin fails++; $display("FAIL ovr_e_width: got %0d pulses max width %0d need 2,1", r2, hmax); end
      tests++;
      // 2 setup + 1 E + 1 hold + 50 gap + 2 setup + 1 E + 1 hold + 1 wait, then IDLE
      if (dr != 60) begin fails++; $display("FAIL ovr_done_time: got %0d need 60", dr); end
      tests++;
   endtask

   initial begin
      test_reset();
      test_single_cmd();
      test_back_to_back();
      test_nibble();
      test_busy_ignore();
      test_reset_mid();
      test_override();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
